// File: rtl/mig_ecc_dec_fix_pipe.sv
// Read-path SECDED decoder: per-beat syndrome, single-bit data correction, multi-bit flagging,
// saturating error counters and a sticky first-error tag, delivered through a 2-stage pipeline.
module mig_ecc_dec_fix_pipe #(
    parameter int PAYLOAD_WIDTH = 64,
    parameter int CODE_WIDTH    = 72,
    parameter int DATA_WIDTH    = 64,
    parameter int DQ_WIDTH      = 72,
    parameter int ECC_WIDTH     = 8,
    parameter int nCK_PER_CLK   = 4,
    parameter int ADDR_WIDTH    = 5,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [CODE_WIDTH*ECC_WIDTH-1:0]         h_rows,
    input  logic [2*nCK_PER_CLK*DQ_WIDTH-1:0]       phy_rddata,
    input  logic                                    phy_rd_valid,
    input  logic [ADDR_WIDTH-1:0]                   rd_addr,
    input  logic                                    correct_en,
    input  logic                                    err_clr,
    output logic [2*nCK_PER_CLK*PAYLOAD_WIDTH-1:0]  rd_data,
    output logic                                    rd_data_valid,
    output logic [ADDR_WIDTH-1:0]                   rd_data_addr,
    output logic [2*nCK_PER_CLK-1:0]                ecc_single,
    output logic [2*nCK_PER_CLK-1:0]                ecc_multiple,
    output logic [ERR_CNT_WIDTH-1:0]                err_cnt_single,
    output logic [ERR_CNT_WIDTH-1:0]                err_cnt_multiple,
    output logic [ADDR_WIDTH-1:0]                   err_addr,
    output logic                                    err_addr_valid
);

    localparam int NBEATS = 2 * nCK_PER_CLK;
    // Only the low bits that can reach rd_data are carried past stage 1.
    localparam int KEEP_W = (PAYLOAD_WIDTH > DATA_WIDTH) ? PAYLOAD_WIDTH : DATA_WIDTH;

    logic [DATA_WIDTH-1:0][ECC_WIDTH-1:0] h_col;
    logic [NBEATS-1:0][ECC_WIDTH-1:0]     syn_d;
    logic [NBEATS-1:0][ECC_WIDTH-1:0]     s1_syn;
    logic [NBEATS*KEEP_W-1:0]             s1_beats;
    logic                                 s1_valid;
    logic                                 s1_correct_en;
    logic [ADDR_WIDTH-1:0]                s1_addr;
    logic [NBEATS*PAYLOAD_WIDTH-1:0]      payload_d;
    logic [NBEATS-1:0]                    single_d;
    logic [NBEATS-1:0]                    multiple_d;
    logic [KEEP_W-1:0]                    fix_beat;
    logic                                 fixed;
    logic                                 any_single;
    logic                                 any_multiple;

    always_comb begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
            for (int k = 0; k < ECC_WIDTH; k++) begin
                h_col[i][k] = h_rows[k*CODE_WIDTH + i];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NBEATS; j++) begin
            for (int k = 0; k < ECC_WIDTH; k++) begin
                syn_d[j][k] = ^(phy_rddata[j*DQ_WIDTH +: CODE_WIDTH] & h_rows[k*CODE_WIDTH +: CODE_WIDTH]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_correct_en <= 1'b0;
            s1_addr       <= '0;
            s1_syn        <= '0;
            s1_beats      <= '0;
        end else begin
            s1_valid <= phy_rd_valid;
            if (phy_rd_valid) begin
                s1_correct_en <= correct_en;
                s1_addr       <= rd_addr;
                s1_syn        <= syn_d;
                for (int j = 0; j < NBEATS; j++) begin
                    s1_beats[j*KEEP_W +: KEEP_W] <= phy_rddata[j*DQ_WIDTH +: KEEP_W];
                end
            end
        end
    end

    // Odd-weight syndromes are correctable; only data columns are searched, so check-bit errors leave data intact.
    always_comb begin
        payload_d  = '0;
        single_d   = '0;
        multiple_d = '0;
        fix_beat   = '0;
        fixed      = 1'b0;
        for (int j = 0; j < NBEATS; j++) begin
            fix_beat = s1_beats[j*KEEP_W +: KEEP_W];
            fixed    = 1'b0;
            if (s1_syn[j] != '0) begin
                single_d[j]   = ^s1_syn[j];
                multiple_d[j] = ~^s1_syn[j];
            end
            if (single_d[j] && s1_correct_en) begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    if (!fixed && (h_col[i] == s1_syn[j])) begin
                        fix_beat[i] = ~fix_beat[i];
                        fixed       = 1'b1;
                    end
                end
            end
            payload_d[j*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = fix_beat[PAYLOAD_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
            rd_data_addr  <= '0;
            ecc_single    <= '0;
            ecc_multiple  <= '0;
        end else begin
            rd_data_valid <= s1_valid;
            ecc_single    <= s1_valid ? single_d : '0;
            ecc_multiple  <= s1_valid ? multiple_d : '0;
            if (s1_valid) begin
                rd_data      <= payload_d;
                rd_data_addr <= s1_addr;
            end
        end
    end

    assign any_single   = rd_data_valid & (|ecc_single);
    assign any_multiple = rd_data_valid & (|ecc_multiple);

    // A clear coinciding with an error restarts the counters at that error and re-arms the capture on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_single   <= '0;
            err_cnt_multiple <= '0;
            err_addr         <= '0;
            err_addr_valid   <= 1'b0;
        end else begin
            if (err_clr) begin
                err_cnt_single <= ERR_CNT_WIDTH'(any_single);
            end else if (any_single && (err_cnt_single != '1)) begin
                err_cnt_single <= err_cnt_single + ERR_CNT_WIDTH'(1);
            end

            if (err_clr) begin
                err_cnt_multiple <= ERR_CNT_WIDTH'(any_multiple);
            end else if (any_multiple && (err_cnt_multiple != '1)) begin
                err_cnt_multiple <= err_cnt_multiple + ERR_CNT_WIDTH'(1);
            end

            if ((err_clr || !err_addr_valid) && (any_single || any_multiple)) begin
                err_addr       <= rd_data_addr;
                err_addr_valid <= 1'b1;
            end else if (err_clr) begin
                err_addr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mig_ecc_dec_fix_pipe.sv
// Directed bench for mig_ecc_dec_fix_pipe: a SECDED H matrix and encoder are built locally,
// then corrupted codewords are pushed through and outputs compared against hand-derived values.
module tb_mig_ecc_dec_fix_pipe;

    localparam int NB   = 8;
    localparam int DQ   = 72;
    localparam int PW   = 64;
    localparam int CW   = 72;
    localparam int EW   = 8;
    localparam int AW   = 5;
    localparam int CNTW = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [CW*EW-1:0]   h_rows;
    logic [NB*DQ-1:0]   phy_rddata;
    logic               phy_rd_valid;
    logic [AW-1:0]      rd_addr;
    logic               correct_en;
    logic               err_clr;
    logic [NB*PW-1:0]   rd_data;
    logic               rd_data_valid;
    logic [AW-1:0]      rd_data_addr;
    logic [NB-1:0]      ecc_single;
    logic [NB-1:0]      ecc_multiple;
    logic [CNTW-1:0]    err_cnt_single;
    logic [CNTW-1:0]    err_cnt_multiple;
    logic [AW-1:0]      err_addr;
    logic               err_addr_valid;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0]      hcol [CW];
    logic [63:0]        dgood = 64'hDEAD_BEEF_0123_4567;
    logic [CW-1:0]      cw_good;
    logic [NB*DQ-1:0]   good_beats;
    logic [NB*PW-1:0]   good_data;
    logic [NB*DQ-1:0]   beats;
    logic [NB*PW-1:0]   exp_data;

    mig_ecc_dec_fix_pipe #(
        .PAYLOAD_WIDTH (PW),
        .CODE_WIDTH    (CW),
        .DATA_WIDTH    (64),
        .DQ_WIDTH      (DQ),
        .ECC_WIDTH     (EW),
        .nCK_PER_CLK   (4),
        .ADDR_WIDTH    (AW),
        .ERR_CNT_WIDTH (CNTW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .h_rows           (h_rows),
        .phy_rddata       (phy_rddata),
        .phy_rd_valid     (phy_rd_valid),
        .rd_addr          (rd_addr),
        .correct_en       (correct_en),
        .err_clr          (err_clr),
        .rd_data          (rd_data),
        .rd_data_valid    (rd_data_valid),
        .rd_data_addr     (rd_data_addr),
        .ecc_single       (ecc_single),
        .ecc_multiple     (ecc_multiple),
        .err_cnt_single   (err_cnt_single),
        .err_cnt_multiple (err_cnt_multiple),
        .err_addr         (err_addr),
        .err_addr_valid   (err_addr_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [CW-1:0] encode(input logic [63:0] d);
        logic [EW-1:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            if (d[i]) c = c ^ hcol[i];
        end
        return {c, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NB*DQ-1:0] b, input logic [AW-1:0] tag, input logic cen);
        phy_rddata   = b;
        rd_addr      = tag;
        correct_en   = cen;
        phy_rd_valid = 1'b1;
        tick();
        phy_rd_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [NB*DQ-1:0] obs, input logic [NB*DQ-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        phy_rd_valid = 1'b0;
        phy_rddata   = '0;
        rd_addr      = '0;
        correct_en   = 1'b0;
        err_clr      = 1'b0;
        h_rows       = '0;

        // Data columns: all weight-3 patterns then weight-5 until 64; check columns are unit vectors.
        n = 0;
        for (int w = 3; w <= 5; w += 2) begin
            for (int v = 0; v < 256; v++) begin
                if (n < 64 && $countones(v) == w) begin
                    hcol[n] = 8'(v);
                    n++;
                end
            end
        end
        for (int k = 0; k < EW; k++) hcol[64+k] = 8'(1 << k);
        for (int k = 0; k < EW; k++) begin
            for (int i = 0; i < CW; i++) h_rows[k*CW + i] = hcol[i][k];
        end
        cw_good    = encode(dgood);
        good_beats = {NB{cw_good}};
        good_data  = {NB{dgood}};

        tick();
        tick();
        checkOutput("reset_valid", rd_data_valid, 0);
        checkOutput("reset_data", rd_data, 0);
        checkOutput("reset_cnt_single", err_cnt_single, 0);
        checkOutput("reset_addr_valid", err_addr_valid, 0);
        #1 rst_n = 1'b1;
        tick();

        $display("[TB] all-zero beats, tag 3");
        applyStimulus('0, 5'd3, 1'b1);
        checkOutput("t1_not_yet_valid", rd_data_valid, 0);
        tick();
        checkOutput("t1_valid", rd_data_valid, 1);
        checkOutput("t1_data", rd_data, 0);
        checkOutput("t1_addr", rd_data_addr, 3);
        checkOutput("t1_single", ecc_single, 0);
        checkOutput("t1_multiple", ecc_multiple, 0);
        tick();
        checkOutput("t1_valid_drop", rd_data_valid, 0);
        checkOutput("t1_cnt_single", err_cnt_single, 0);
        checkOutput("t1_cnt_multiple", err_cnt_multiple, 0);
        checkOutput("t1_addr_valid", err_addr_valid, 0);

        $display("[TB] single data error beat 2 bit 5, corrected, tag 9");
        beats = good_beats;
        beats[2*DQ + 5] = ~beats[2*DQ + 5];
        applyStimulus(beats, 5'd9, 1'b1);
        tick();
        checkOutput("t2_valid", rd_data_valid, 1);
        checkOutput("t2_data", rd_data, good_data);
        checkOutput("t2_single", ecc_single, 8'h04);
        checkOutput("t2_multiple", ecc_multiple, 0);
        checkOutput("t2_addr", rd_data_addr, 9);
        tick();
        checkOutput("t2_flags_idle", ecc_single, 0);
        checkOutput("t2_data_hold", rd_data, good_data);
        checkOutput("t2_cnt_single", err_cnt_single, 1);
        checkOutput("t2_err_addr", err_addr, 9);
        checkOutput("t2_err_addr_valid", err_addr_valid, 1);

        $display("[TB] same error, correction disabled, tag 10");
        applyStimulus(beats, 5'd10, 1'b0);
        tick();
        exp_data = good_data;
        exp_data[2*PW + 5] = ~exp_data[2*PW + 5];
        checkOutput("t3_data", rd_data, exp_data);
        checkOutput("t3_single", ecc_single, 8'h04);
        tick();
        checkOutput("t3_cnt_single", err_cnt_single, 2);
        checkOutput("t3_err_addr_kept", err_addr, 9);

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("clr_cnt_single", err_cnt_single, 0);
        checkOutput("clr_addr_valid", err_addr_valid, 0);

        $display("[TB] double error beat 7, then check-bit error beat 0");
        beats = good_beats;
        beats[7*DQ + 0] = ~beats[7*DQ + 0];
        beats[7*DQ + 1] = ~beats[7*DQ + 1];
        applyStimulus(beats, 5'd11, 1'b1);
        tick();
        exp_data = good_data;
        exp_data[7*PW + 0] = ~exp_data[7*PW + 0];
        exp_data[7*PW + 1] = ~exp_data[7*PW + 1];
        checkOutput("t4a_data", rd_data, exp_data);
        checkOutput("t4a_multiple", ecc_multiple, 8'h80);
        checkOutput("t4a_single", ecc_single, 0);
        tick();
        beats = good_beats;
        beats[64] = ~beats[64];
        applyStimulus(beats, 5'd12, 1'b1);
        tick();
        checkOutput("t4b_data", rd_data, good_data);
        checkOutput("t4b_single", ecc_single, 8'h01);
        checkOutput("t4b_multiple", ecc_multiple, 0);
        checkOutput("t4b_addr", rd_data_addr, 12);
        tick();
        checkOutput("t4_cnt_single", err_cnt_single, 1);
        checkOutput("t4_cnt_multiple", err_cnt_multiple, 1);
        checkOutput("t4_err_addr", err_addr, 11);
        checkOutput("t4_err_addr_valid", err_addr_valid, 1);

        $display("[TB] 20 consecutive single-error cycles");
        beats = good_beats;
        beats[3*DQ + 40] = ~beats[3*DQ + 40];
        phy_rddata   = beats;
        rd_addr      = 5'd20;
        correct_en   = 1'b1;
        phy_rd_valid = 1'b1;
        repeat (20) tick();
        phy_rd_valid = 1'b0;
        repeat (3) tick();
        checkOutput("t5_cnt_saturated", err_cnt_single, 15);
        checkOutput("t5_cnt_multiple", err_cnt_multiple, 1);
        checkOutput("t5_err_addr_kept", err_addr, 11);

        beats = good_beats;
        beats[6*DQ + 63] = ~beats[6*DQ + 63];
        applyStimulus(beats, 5'd21, 1'b1);
        tick();
        checkOutput("t5_clr_single", ecc_single, 8'h40);
        checkOutput("t5_clr_data", rd_data, good_data);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("t5_clr_cnt_single", err_cnt_single, 1);
        checkOutput("t5_clr_cnt_multiple", err_cnt_multiple, 0);
        checkOutput("t5_clr_err_addr", err_addr, 21);
        checkOutput("t5_clr_addr_valid", err_addr_valid, 1);
        tick();
        checkOutput("t5_clr_cnt_stable", err_cnt_single, 1);

        $display("[TB] back-to-back tags 1,2,3 with reset mid-flight");
        phy_rddata   = good_beats;
        correct_en   = 1'b1;
        rd_addr      = 5'd1;
        phy_rd_valid = 1'b1;
        tick();
        rd_addr = 5'd2;
        tick();
        checkOutput("t6_tag1_valid", rd_data_valid, 1);
        checkOutput("t6_tag1_addr", rd_data_addr, 1);
        checkOutput("t6_tag1_data", rd_data, good_data);
        rd_addr = 5'd3;
        #1 rst_n = 1'b0;
        phy_rd_valid = 1'b0;
        #1;
        checkOutput("t6_rst_valid", rd_data_valid, 0);
        checkOutput("t6_rst_data", rd_data, 0);
        checkOutput("t6_rst_addr", rd_data_addr, 0);
        checkOutput("t6_rst_cnt", err_cnt_single, 0);
        checkOutput("t6_rst_addr_valid", err_addr_valid, 0);
        tick();
        tick();
        checkOutput("t6_rst_hold_valid", rd_data_valid, 0);
        #2 rst_n = 1'b1;
        tick();
        checkOutput("t6_no_tag2", rd_data_valid, 0);
        tick();
        checkOutput("t6_no_tag3", rd_data_valid, 0);
        applyStimulus(good_beats, 5'd7, 1'b1);
        checkOutput("t6_new_not_yet", rd_data_valid, 0);
        tick();
        checkOutput("t6_new_valid", rd_data_valid, 1);
        checkOutput("t6_new_addr", rd_data_addr, 7);
        checkOutput("t6_new_data", rd_data, good_data);
        tick();
        checkOutput("t6_new_drop", rd_data_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
